// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: fetch PC owner, imem req/ack sequencer and one-entry IF/ID buffer.
// Define NPC_DELAY_SLOT_EN for MIPS-style branch delay slot handling of redirects.
module pc_fetch_sequencer #(
  parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [29:0] redir_pc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [29:0] if_pc,
  output logic [29:0] if_pc_plus1,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        flush
);
  typedef enum logic {FETCH_IDLE, FETCH_WAIT} state_t;
  state_t      state, state_nx;
  logic [29:0] pc, pc_nx, addr, addr_nx;
  logic        discard, discard_nx, valid_nx;
  logic        ack, issue, accept, cap, kill;
  // discard: outstanding fetch is stale (delay-slot build: pc already holds the redirect target)
  always_comb begin
    ack = state == FETCH_WAIT && imem_ack;
    issue = state == FETCH_IDLE && !stall && !redir_valid && (!if_valid || if_ready);
    accept = if_valid && if_ready && !stall;
`ifdef NPC_DELAY_SLOT_EN
    cap = ack;
    kill = 1'b0;
    pc_nx = redir_valid ? redir_pc : (cap && !discard) ? pc + 30'd1 : pc;
`else
    cap = ack && !discard && !redir_valid;
    kill = redir_valid;
    pc_nx = redir_valid ? redir_pc : cap ? pc + 30'd1 : pc;
`endif
    discard_nx = ack ? 1'b0 : (redir_valid && state == FETCH_WAIT) ? 1'b1 : discard;
    state_nx = ack ? FETCH_IDLE : issue ? FETCH_WAIT : state;
    addr_nx = issue ? pc : addr;
    valid_nx = cap || (if_valid && !accept && !kill);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH_IDLE;
      pc <= RESET_PC;
      addr <= '0;
      discard <= 1'b0;
      if_valid <= 1'b0;
      if_pc <= '0;
      if_instr <= '0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      addr <= addr_nx;
      discard <= discard_nx;
      if_valid <= valid_nx;
      if (cap) begin
        if_pc <= addr;
        if_instr <= imem_rdata;
      end
    end
  end
  assign imem_req = state == FETCH_WAIT;
  assign imem_addr = addr;
  assign if_pc_plus1 = if_pc + 30'd1;
  assign flush = kill && rst_n;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: table-driven cycle vectors plus hand sequences for reset, wrap and redirect-with-ack.
module tb_pc_fetch_sequencer;
`ifdef NPC_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, redir_valid = 1'b0, if_ready = 1'b1;
  logic [29:0] redir_pc = '0;
  logic        imem_req, imem_ack, if_valid, flush;
  logic [29:0] imem_addr, if_pc, if_pc_plus1;
  logic [31:0] imem_rdata, if_instr;
  int          wcnt = 0, checks = 0, failures = 0;
  typedef struct {
    logic st, rv, rdy;
    logic [29:0] rpc;
    logic req, vld, fl;
    logic [29:0] addr, pc;
  } vec_t;
  vec_t tbl[29];
  pc_fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus1(if_pc_plus1), .if_instr(if_instr),
    .if_ready(if_ready), .flush(flush)
  );
  always #5 clk = ~clk;
  // memory answers in the second cycle of each request
  assign imem_ack = imem_req && wcnt >= 1;
  assign imem_rdata = imem_ack ? {2'b01, imem_addr} : 32'h0;
  always @(posedge clk) wcnt <= (imem_req && !imem_ack) ? wcnt + 1 : 0;
  function automatic vec_t mk(input logic st, rv, input logic [29:0] rpc, input logic rdy,
                              input logic req, input logic [29:0] addr, input logic vld,
                              input logic [29:0] pc, input logic fl);
    vec_t v;
    v.st = st; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.fl = fl;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask
  task automatic expect_o(input string tag, input logic req, input logic [29:0] addr,
                          input logic vld, input logic [29:0] pc, input logic fl);
    logic [29:0] p1;
    p1 = pc + 30'd1;
    chk({tag, ".imem_req"}, 32'(imem_req), 32'(req));
    if (req) chk({tag, ".imem_addr"}, 32'(imem_addr), 32'(addr));
    chk({tag, ".if_valid"}, 32'(if_valid), 32'(vld));
    if (vld) begin
      chk({tag, ".if_pc"}, 32'(if_pc), 32'(pc));
      chk({tag, ".if_pc_plus1"}, 32'(if_pc_plus1), 32'(p1));
      chk({tag, ".if_instr"}, if_instr, {2'b01, pc});
    end
    chk({tag, ".flush"}, 32'(flush), 32'(fl));
  endtask
  task automatic step(input logic s, r, input logic [29:0] rp, input logic rdy);
    @(negedge clk);
    stall = s; redir_valid = r; redir_pc = rp; if_ready = rdy;
    #1;
  endtask
  initial begin
    tbl[0]  = mk(0, 0, 0, 1,       0, 0,     0, 0,     0);
    tbl[1]  = mk(0, 0, 0, 1,       1, 'hC00, 0, 0,     0);
    tbl[2]  = mk(0, 0, 0, 1,       1, 'hC00, 0, 0,     0);
    tbl[3]  = mk(0, 0, 0, 1,       0, 0,     1, 'hC00, 0);
    tbl[4]  = mk(0, 0, 0, 1,       1, 'hC01, 0, 0,     0);
    tbl[5]  = mk(0, 0, 0, 1,       1, 'hC01, 0, 0,     0);
    tbl[6]  = mk(0, 0, 0, 1,       0, 0,     1, 'hC01, 0);
    tbl[7]  = mk(0, 0, 0, 1,       1, 'hC02, 0, 0,     0);
    tbl[8]  = mk(0, 0, 0, 1,       1, 'hC02, 0, 0,     0);
    tbl[9]  = mk(0, 0, 0, 1,       0, 0,     1, 'hC02, 0);
    tbl[10] = mk(1, 0, 0, 1,       1, 'hC03, 0, 0,     0);
    tbl[11] = mk(1, 0, 0, 1,       1, 'hC03, 0, 0,     0);
    tbl[12] = mk(1, 0, 0, 1,       0, 0,     1, 'hC03, 0);
    tbl[13] = mk(1, 0, 0, 1,       0, 0,     1, 'hC03, 0);
    tbl[14] = mk(1, 0, 0, 1,       0, 0,     1, 'hC03, 0);
    tbl[15] = mk(0, 0, 0, 1,       0, 0,     1, 'hC03, 0);
    tbl[16] = mk(0, 0, 0, 1,       1, 'hC04, 0, 0,     0);
    tbl[17] = mk(0, 0, 0, 1,       1, 'hC04, 0, 0,     0);
    tbl[18] = mk(0, 0, 0, 1,       0, 0,     1, 'hC04, 0);
    tbl[19] = mk(0, 1, 'h100, 1,   1, 'hC05, 0, 0,     !DS);
    tbl[20] = mk(0, 0, 0, 1,       1, 'hC05, 0, 0,     0);
    tbl[21] = mk(0, 0, 0, 1,       0, 0,     DS, 'hC05, 0);
    tbl[22] = mk(0, 0, 0, 1,       1, 'h100, 0, 0,     0);
    tbl[23] = mk(0, 0, 0, 1,       1, 'h100, 0, 0,     0);
    tbl[24] = mk(0, 0, 0, 0,       0, 0,     1, 'h100, 0);
    tbl[25] = mk(0, 0, 0, 0,       0, 0,     1, 'h100, 0);
    tbl[26] = mk(0, 0, 0, 0,       0, 0,     1, 'h100, 0);
    tbl[27] = mk(0, 0, 0, 1,       0, 0,     1, 'h100, 0);
    tbl[28] = mk(0, 0, 0, 1,       1, 'h101, 0, 0,     0);
    #1;
    chk("rst.imem_req", 32'(imem_req), 32'h0);
    chk("rst.if_valid", 32'(if_valid), 32'h0);
    chk("rst.if_pc", 32'(if_pc), 32'h0);
    chk("rst.if_instr", if_instr, 32'h0);
    chk("rst.flush", 32'(flush), 32'h0);
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      stall = tbl[i].st; redir_valid = tbl[i].rv; redir_pc = tbl[i].rpc; if_ready = tbl[i].rdy;
      #1;
      expect_o($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].pc, tbl[i].fl);
    end
    #2 rst_n = 1'b0;
    #1;
    expect_o("midrst", 0, 0, 0, 0, 0);
    chk("midrst.if_pc", 32'(if_pc), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expect_o("rel0", 0, 0, 0, 0, 0);
    step(0, 0, 0, 1);
    expect_o("rel1", 1, 'hC00, 0, 0, 0);
    step(0, 1, 30'h3FFF_FFFF, 1);
    expect_o("redir_ack", 1, 'hC00, 0, 0, !DS);
    step(0, 0, 0, 1);
    expect_o("redir_ack+1", 0, 0, DS, 'hC00, 0);
    step(0, 0, 0, 1);
    expect_o("wrap_req", 1, 30'h3FFF_FFFF, 0, 0, 0);
    step(0, 0, 0, 1);
    expect_o("wrap_ack", 1, 30'h3FFF_FFFF, 0, 0, 0);
    step(0, 0, 0, 1);
    expect_o("wrap_buf", 0, 0, 1, 30'h3FFF_FFFF, 0);
    step(0, 0, 0, 1);
    expect_o("wrap_next", 1, 30'h0, 0, 0, 0);
    step(0, 0, 0, 1);
    expect_o("wrap_next_ack", 1, 30'h0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
